dct_mac_acc: RTL and testbench

Multiply-accumulate stage of the forward-DCT unit inside `fdct_zigzag.dct_mod.dct_block_N.dct_unit_N`. It registers the signed product of a pixel sample and a cosine coefficient into `mult_res`, then accumulates `TERMS` consecutive products into one DCT coefficient. It is the consumer of the `mult_res` register and the producer of the coefficient fed to the unit's output rounding stage. The block is fully pipelined at one term per enabled clock.

---
 rtl/dct_mac_acc.sv | 109 ++++++++++
 tb/tb_dct_mac_acc.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dct_mac_acc.sv
// dct_mac_acc
//   Multiply-accumulate stage of the forward-DCT unit.
//   Stage 1 registers the signed product din*coef into mult_res.
//   Stage 2 accumulates TERMS consecutive products into one DCT coefficient.
//   Throughput is one term per enabled clock.
//
// Parameters
//   DWIDTH  signed pixel sample width
//   CWIDTH  signed coefficient width
//   AWIDTH  signed accumulator/result width (>= DWIDTH+CWIDTH)
//   TERMS   products per coefficient (power of two, 2..16)
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous reset, active-low
//   ena     global clock enable; one term per enabled cycle, all state frozen when low
//   dclr    marks the current term as the first term of a new sum
//   din     signed pixel sample
//   coef    signed cosine coefficient
//   result  signed completed sum; holds its value until the next completion
//   done    one-clock pulse when result has just been updated
//
// Build option
//   DCT_MAC_SAT_EN  when defined, the accumulate saturates to the signed
//                   AWIDTH limits; otherwise it wraps (two's complement).

module dct_mac_acc #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 8,
  parameter int AWIDTH = 24,
  parameter int TERMS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     dclr,
  input  logic signed [DWIDTH-1:0] din,
  input  logic signed [CWIDTH-1:0] coef,
  output logic signed [AWIDTH-1:0] result,
  output logic                     done
);

  localparam int PWIDTH = DWIDTH + CWIDTH;
  localparam int CNTW   = $clog2(TERMS) + 1;

`ifdef DCT_MAC_SAT_EN
  localparam logic signed [AWIDTH-1:0] ACC_MAX = {1'b0, {(AWIDTH-1){1'b1}}};
  localparam logic signed [AWIDTH-1:0] ACC_MIN = {1'b1, {(AWIDTH-1){1'b0}}};
`endif

  logic signed [PWIDTH-1:0] mult_res;
  logic                     clr_d1;
  // mult_res only holds a real term once an enabled cycle has passed since
  // reset; stage 2 skips the reset bubble so the first block still spans
  // exactly TERMS presented terms.
  logic                     vld_d1;
  logic signed [AWIDTH-1:0] acc;
  logic [CNTW-1:0]          cnt;

  logic signed [AWIDTH-1:0] p;
  logic signed [AWIDTH-1:0] sum;
  logic signed [AWIDTH-1:0] sum_s;
  logic signed [AWIDTH-1:0] acc_nxt;
  logic [CNTW-1:0]          cnt_nxt;
  logic                     start;

  always_comb begin
    p     = AWIDTH'(mult_res);
    sum   = acc + p;
    sum_s = sum;
`ifdef DCT_MAC_SAT_EN
    // Overflow only when both operands share a sign and the sum flips it.
    if ((acc[AWIDTH-1] == p[AWIDTH-1]) && (sum[AWIDTH-1] != acc[AWIDTH-1]))
      sum_s = acc[AWIDTH-1] ? ACC_MIN : ACC_MAX;
`endif
    // Start a new sum on an explicit clear or right after a completion.
    start   = clr_d1 || (cnt == CNTW'(TERMS));
    acc_nxt = start ? p : sum_s;
    cnt_nxt = start ? CNTW'(1) : cnt + CNTW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mult_res <= '0;
      clr_d1   <= 1'b0;
      vld_d1   <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      result   <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (ena) begin
        mult_res <= PWIDTH'(din) * PWIDTH'(coef);
        clr_d1   <= dclr;
        vld_d1   <= 1'b1;
        if (vld_d1) begin
          acc <= acc_nxt;
          cnt <= cnt_nxt;
          if (cnt_nxt == CNTW'(TERMS)) begin
            result <= acc_nxt;
            done   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_mac_acc.sv
module tb_dct_mac_acc;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic ena  = 1'b0;
  logic dclr = 1'b0;
  logic signed [7:0] din  = '0;
  logic signed [7:0] coef = '0;

  logic signed [23:0] result;
  logic               done;
  logic signed [15:0] result16;
  logic               done16;

  int errors = 0;
  int checks = 0;

`ifdef DCT_MAC_SAT_EN
  localparam int OVF_EXP = 32767;
`else
  localparam int OVF_EXP = -2040;
`endif

  always #5 clk = ~clk;

  dct_mac_acc #(.DWIDTH(8), .CWIDTH(8), .AWIDTH(24), .TERMS(8)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .dclr(dclr),
    .din(din), .coef(coef), .result(result), .done(done)
  );

  dct_mac_acc #(.DWIDTH(8), .CWIDTH(8), .AWIDTH(16), .TERMS(8)) u_dut16 (
    .clk(clk), .rst(rst), .ena(ena), .dclr(dclr),
    .din(din), .coef(coef), .result(result16), .done(done16)
  );

  // Inputs change on the falling edge; outputs read there reflect the last rising edge.
  task automatic drive(input logic e, input logic c, input int d, input int k);
    @(negedge clk);
    ena  = e;
    dclr = c;
    din  = 8'(d);
    coef = 8'(k);
  endtask

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    // Reset
    #2;
    chk("rst_result", result, 0);
    chk("rst_done", done, 0);
    chk("rst_result16", result16, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Basic sum: 8 x (10*3) = 240
    drive(1, 1, 10, 3);
    for (int i = 2; i <= 8; i++) drive(1, 0, 10, 3);
    drive(1, 0, 0, 0);
    chk("basic_done_early", done, 0);
    drive(0, 0, 0, 0);
    chk("basic_done", done, 1);
    chk("basic_result", result, 240);
    drive(0, 0, 0, 0);
    chk("basic_done_pulse", done, 0);
    chk("basic_hold", result, 240);

    // Negative products, then back-to-back block without dclr
    drive(1, 1, -128, 127);
    for (int i = 2; i <= 8; i++) drive(1, 0, -128, 127);
    drive(1, 0, 1, -1);
    chk("neg_done_early", done, 0);
    drive(1, 0, 1, -1);
    chk("neg_done", done, 1);
    chk("neg_result", result, -130048);
    for (int i = 3; i <= 8; i++) drive(1, 0, 1, -1);
    chk("auto_hold", result, -130048);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("auto_done", done, 1);
    chk("auto_result", result, -8);

    // Enable gaps after terms 2 and 6
    drive(1, 1, 10, 3);
    drive(1, 0, 10, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk("gap1_done", done, 0);
    end
    for (int i = 3; i <= 6; i++) drive(1, 0, 10, 3);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      chk("gap2_done", done, 0);
    end
    drive(1, 0, 10, 3);
    drive(1, 0, 10, 3);
    drive(1, 0, 0, 0);
    chk("gap_done_early", done, 0);
    drive(0, 0, 0, 0);
    chk("gap_done", done, 1);
    chk("gap_result", result, 240);

    // Abort: 5 terms of 5*5, then dclr and 8 terms of 1*2
    drive(1, 1, 5, 5);
    for (int i = 2; i <= 5; i++) drive(1, 0, 5, 5);
    drive(1, 1, 1, 2);
    chk("abort_done_a", done, 0);
    for (int i = 2; i <= 8; i++) begin
      drive(1, 0, 1, 2);
      chk("abort_done_b", done, 0);
    end
    drive(1, 0, 0, 0);
    chk("abort_done_c", done, 0);
    drive(0, 0, 0, 0);
    chk("abort_done", done, 1);
    chk("abort_result", result, 16);
    drive(0, 0, 0, 0);
    chk("abort_single", done, 0);

    // Reset mid-block
    drive(1, 1, 10, 3);
    for (int i = 2; i <= 4; i++) drive(1, 0, 10, 3);
    drive(0, 0, 0, 0);
    chk("pre_rst_result", result, 16);
    #2 rst = 1'b0;
    #1;
    chk("midrst_result", result, 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 1; i <= 8; i++) drive(1, 0, 1, 1);
    drive(1, 0, 0, 0);
    chk("postrst_done_early", done, 0);
    drive(0, 0, 0, 0);
    chk("postrst_done", done, 1);
    chk("postrst_result", result, 8);

    // Overflow on the 16-bit accumulator
    drive(1, 1, 127, 127);
    for (int i = 2; i <= 8; i++) drive(1, 0, 127, 127);
    drive(1, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("ovf_done16", done16, 1);
    chk("ovf_result16", result16, OVF_EXP);
    chk("ovf_result24", result, 129032);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
